// File: rtl/flash_spi_pkg.sv
// Shared state encoding, idle clock level and bit-order helper for the flash SPI master.
package flash_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  localparam logic FCK_IDLE = 1'b1;

  // Reverse the low w bits of v; result bits at and above w are zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w - 1 - i];
      else       r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/flash_spi_master_tick.sv
// Loadable half-period down-counter; tick_o flags the cycle in which the count is zero.
module flash_spi_master_tick #(
  parameter int DIVW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [DIVW-1:0] load_val_i,
  output logic            tick_o
);

  logic [DIVW-1:0] cnt_q;
  logic [DIVW-1:0] cnt_d;

  // Next count: reload wins, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {DIVW{1'b0}}) begin
      cnt_d = cnt_q - {{(DIVW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= {DIVW{1'b0}};
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == {DIVW{1'b0}});

endmodule

// File: rtl/flash_spi_master.sv
// Mode-3 SPI master for the configuration flash: programmable rate, bit order and chip selects.
module flash_spi_master
  import flash_spi_pkg::*;
#(
  parameter int DW   = 8,
  parameter int DIVW = 4,
  parameter int NCS  = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ENABLE,
  input  logic            WS,
  input  logic            RS,
  input  logic [DW-1:0]   DIN,
  output logic [DW-1:0]   DOUT,
  input  logic [DIVW-1:0] DIV,
  input  logic            LSBF,
  input  logic            CSW,
  input  logic [NCS-1:0]  CSD,
  output logic            BUSY,
  output logic            DONE,
  output logic            OVR,
  input  logic            SI,
  output logic            SO,
  output logic            FCK,
  output logic [NCS-1:0]  CSN
);

  localparam int BCW = $clog2(DW + 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   osreg_q, osreg_d;
  logic [DW-1:0]   isreg_q, isreg_d;
  logic [BCW-1:0]  bc_q, bc_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            lsbf_q, lsbf_d;
  logic            fck_q, fck_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic [NCS-1:0]  csreg_q, csreg_d;

  logic            tick_s;
  logic            hc_load_s;
  logic [DIVW-1:0] hc_val_s;
  logic [DW-1:0]   din_rev_s;

  flash_spi_master_tick #(.DIVW(DIVW)) u_tick (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (hc_load_s),
    .load_val_i (hc_val_s),
    .tick_o     (tick_s)
  );

  assign din_rev_s = DW'(bit_rev(32'(DIN), DW));

  // Transfer FSM: the final HIGH half is folded into IDLE, so DONE coincides with the last rising edge.
  always_comb begin
    state_d   = state_q;
    osreg_d   = osreg_q;
    isreg_d   = isreg_q;
    bc_d      = bc_q;
    div_d     = div_q;
    lsbf_d    = lsbf_q;
    fck_d     = fck_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hc_load_s = 1'b0;
    hc_val_s  = div_q;
    case (state_q)
      IDLE: begin
        fck_d = FCK_IDLE;
        if (WS) begin
          osreg_d   = LSBF ? din_rev_s : DIN;
          div_d     = DIV;
          lsbf_d    = LSBF;
          bc_d      = BCW'(DW);
          hc_load_s = 1'b1;
          hc_val_s  = DIV;
          fck_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = LOW;
        end else begin
          state_d = IDLE;
        end
      end
      LOW: begin
        if (tick_s) begin
          fck_d   = 1'b1;
          isreg_d = lsbf_q ? {SI, isreg_q[DW-1:1]} : {isreg_q[DW-2:0], SI};
          if (bc_q == BCW'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            hc_load_s = 1'b1;
            state_d   = HIGH;
          end
        end else begin
          state_d = LOW;
        end
      end
      HIGH: begin
        if (tick_s) begin
          osreg_d   = {osreg_q[DW-2:0], 1'b0};
          bc_d      = bc_q - BCW'(1);
          fck_d     = 1'b0;
          hc_load_s = 1'b1;
          state_d   = LOW;
        end else begin
          state_d = HIGH;
        end
      end
      default: begin
        fck_d   = FCK_IDLE;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Status and chip-select next state; a busy-time WS outranks a simultaneous RS.
  always_comb begin
    ovr_d   = ovr_q;
    csreg_d = csreg_q;
    if (WS && busy_q) begin
      ovr_d = 1'b1;
    end else if (RS) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    if (CSW) csreg_d = CSD;
    else     csreg_d = csreg_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      osreg_q <= {DW{1'b0}};
      isreg_q <= {DW{1'b0}};
      bc_q    <= {BCW{1'b0}};
      div_q   <= {DIVW{1'b0}};
      lsbf_q  <= 1'b0;
      fck_q   <= FCK_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      csreg_q <= {NCS{1'b0}};
    end else begin
      state_q <= state_d;
      osreg_q <= osreg_d;
      isreg_q <= isreg_d;
      bc_q    <= bc_d;
      div_q   <= div_d;
      lsbf_q  <= lsbf_d;
      fck_q   <= fck_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      csreg_q <= csreg_d;
    end
  end

  assign DOUT = isreg_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign OVR  = ovr_q;
  assign SO   = ENABLE ? osreg_q[DW-1] : 1'bz;
  assign FCK  = ENABLE ? fck_q : 1'bz;
  assign CSN  = ENABLE ? ~csreg_q : {NCS{1'bz}};

endmodule

// File: tb/tb_flash_spi_master.sv
// Self-checking bench for flash_spi_master: vector table plus hand-written corner sequences.
module tb_flash_spi_master;

  localparam int DW   = 8;
  localparam int DIVW = 4;
  localparam int NCS  = 2;

  typedef struct {
    logic [DW-1:0]   din;
    logic [DIVW-1:0] div;
    logic            lsbf;
    logic [DW-1:0]   flash;
    logic [DW-1:0]   exp_dout;
  } vec_t;

  logic            clk = 1'b0;
  logic            RST, ENABLE, WS, RS, LSBF, CSW, SI;
  logic [DW-1:0]   DIN;
  logic [DIVW-1:0] DIV;
  logic [NCS-1:0]  CSD;
  wire  [DW-1:0]   DOUT;
  wire             BUSY, DONE, OVR, SO, FCK;
  wire  [NCS-1:0]  CSN;

  logic [NCS-1:0]  cs_exp;
  logic            so_q[$];
  logic [DW-1:0]   dout_q[$];
  int              n_chk  = 0;
  int              n_fail = 0;
  vec_t            vecs[5];
  vec_t            v_tmp;

  flash_spi_master #(.DW(DW), .DIVW(DIVW), .NCS(NCS)) dut (
    .CLK(clk), .RST(RST), .ENABLE(ENABLE), .WS(WS), .RS(RS), .DIN(DIN), .DOUT(DOUT),
    .DIV(DIV), .LSBF(LSBF), .CSW(CSW), .CSD(CSD), .BUSY(BUSY), .DONE(DONE), .OVR(OVR),
    .SI(SI), .SO(SO), .FCK(FCK), .CSN(CSN)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_fck"},  32'(FCK),  32'd1);
    chk({tag, "_csn"},  32'(CSN),  32'd3);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_done"}, 32'(DONE), 32'd0);
    chk({tag, "_ovr"},  32'(OVR),  32'd0);
    chk({tag, "_dout"}, 32'(DOUT), 32'd0);
    chk({tag, "_so"},   32'(SO),   32'd0);
  endtask

  // Called at a negedge; leaves at a negedge one cycle later with CSN checked.
  task automatic cs_write(input logic [NCS-1:0] d);
    logic [NCS-1:0] e;
    CSD = d; CSW = 1'b1;
    @(negedge clk);
    CSW = 1'b0;
    cs_exp = d;
    e = ~d;
    chk("cs_write_csn", 32'(CSN), 32'(e));
  endtask

  // Called at a negedge: WS is raised there and sampled at the next edge E0.
  // Returns at the negedge of cycle E0+(2*DW-1)*(DIV+1), where BUSY reads 0.
  task automatic xfer(input vec_t v, input int ws_at, input int rst_at, input int en_off_at);
    int h, nend, k;
    logic so_e;
    logic [DW-1:0] dout_e;
    logic [NCS-1:0] csn_e;
    logic fck_e;
    h    = int'(v.div) + 1;
    nend = (2 * DW - 1) * h;
    for (int b = 0; b < DW; b++) so_q.push_back(v.lsbf ? v.din[b] : v.din[DW-1-b]);
    dout_q.push_back(v.exp_dout);
    WS = 1'b1; DIN = v.din; DIV = v.div; LSBF = v.lsbf;
    for (int n = 0; n <= nend; n++) begin
      @(posedge clk); #1;
      WS = 1'b0; RS = 1'b0; RST = 1'b0;
      k = n / (2 * h);
      SI = (k < DW) ? (v.lsbf ? v.flash[k] : v.flash[DW-1-k]) : 1'b0;
      if (ws_at >= 0 && (n == ws_at || n == ws_at + 2)) begin
        WS = 1'b1; DIN = ~v.din;
      end
      if (ws_at >= 0 && n == ws_at + 2) RS = 1'b1;
      if (n == en_off_at) ENABLE = 1'b0;
      if (n == rst_at) RST = 1'b1;
      @(negedge clk);
      if (rst_at >= 0 && n == rst_at + 1) begin
        chk_reset_state("rst_abort");
        so_q.delete();
        dout_q.delete();
        cs_exp = {NCS{1'b0}};
        for (int m = 0; m < nend; m++) begin
          @(negedge clk);
          chk("rst_no_done", 32'(DONE), 32'd0);
        end
        return;
      end
      fck_e = (n >= nend) ? 1'b1 : (((n / h) % 2) == 1);
      csn_e = ~cs_exp;
      chk("busy", 32'(BUSY), 32'(n < nend));
      chk("done", 32'(DONE), 32'(n == nend));
      if (ENABLE) begin
        chk("fck", 32'(FCK), 32'(fck_e));
        chk("csn", 32'(CSN), 32'(csn_e));
      end
      if ((n % (2 * h)) == 0 && n < nend) begin
        if (so_q.size() == 0) begin
          chk("so_queue_empty", 32'd1, 32'd0);
        end else begin
          so_e = so_q.pop_front();
          if (ENABLE) chk("so", 32'(SO), 32'(so_e));
        end
      end
      if (n == nend) begin
        if (dout_q.size() == 0) begin
          chk("dout_queue_empty", 32'd1, 32'd0);
        end else begin
          dout_e = dout_q.pop_front();
          chk("dout", 32'(DOUT), 32'(dout_e));
        end
        chk("ovr_end", 32'(OVR), 32'(ws_at >= 0));
      end
    end
    ENABLE = 1'b1;
  endtask

  initial begin
    RST = 1'b1; ENABLE = 1'b1; WS = 1'b0; RS = 1'b0; DIN = '0; DIV = '0; LSBF = 1'b0;
    CSW = 1'b0; CSD = '0; SI = 1'b0; cs_exp = '0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    vecs[0] = '{din: 8'hA5, div: 4'd0, lsbf: 1'b0, flash: 8'h3C, exp_dout: 8'h3C};
    vecs[1] = '{din: 8'h01, div: 4'd3, lsbf: 1'b1, flash: 8'h5A, exp_dout: 8'h5A};
    vecs[2] = '{din: 8'hFF, div: 4'd1, lsbf: 1'b0, flash: 8'h00, exp_dout: 8'h00};
    vecs[3] = '{din: 8'h00, div: 4'd2, lsbf: 1'b1, flash: 8'hFF, exp_dout: 8'hFF};
    vecs[4] = '{din: 8'h81, div: 4'd0, lsbf: 1'b1, flash: 8'hC3, exp_dout: 8'hC3};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      xfer(vecs[i], -1, -1, -1);
    end

    // Overrun: extra WS at E0+5, then RS together with WS; RS alone afterwards clears.
    v_tmp = '{din: 8'h6E, div: 4'd1, lsbf: 1'b0, flash: 8'h92, exp_dout: 8'h92};
    @(negedge clk);
    xfer(v_tmp, 5, -1, -1);
    RS = 1'b1;
    @(negedge clk);
    RS = 1'b0;
    chk("ovr_cleared", 32'(OVR), 32'd0);

    // Chip select held across two back-to-back transfers.
    @(negedge clk);
    cs_write(2'b10);
    v_tmp = '{din: 8'h9F, div: 4'd0, lsbf: 1'b0, flash: 8'hEF, exp_dout: 8'hEF};
    xfer(v_tmp, -1, -1, -1);
    v_tmp = '{din: 8'h12, div: 4'd0, lsbf: 1'b0, flash: 8'h40, exp_dout: 8'h40};
    xfer(v_tmp, -1, -1, -1);
    cs_write(2'b00);

    // Reset in the middle of a transfer.
    @(negedge clk);
    cs_write(2'b01);
    v_tmp = '{din: 8'h77, div: 4'd0, lsbf: 1'b0, flash: 8'hAA, exp_dout: 8'hAA};
    xfer(v_tmp, -1, 7, -1);

    // Outputs released mid-transfer; received word still lands in DOUT.
    @(negedge clk);
    v_tmp = '{din: 8'h3D, div: 4'd1, lsbf: 1'b0, flash: 8'hB6, exp_dout: 8'hB6};
    xfer(v_tmp, -1, -1, 4);
    @(negedge clk);
    chk("enable_back_fck", 32'(FCK), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
